// File: rtl/dla_pkg.sv
// Shared types and constants for the decade-counter load arbiter.
// Holds the FSM state enum, BCD digit limits and the digit clamp helper.
package dla_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CHECK = 2'd2
    } dla_state_e;

    localparam int                  DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0]  DIGIT_MAX = 4'd9;

    // Values that are not legal BCD digits saturate to the largest digit.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v);
        return (v > DIGIT_MAX) ? DIGIT_MAX : v;
    endfunction

endpackage

// File: rtl/dla_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Produces the one-hot winner and its binary index (both zero when nothing is requested).
module dla_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx
);

    logic [PW:0]   sum_s;
    logic [PW-1:0] cand_s;
    logic          hit_s;
    logic          found_s;

    // Scan NREQ candidates starting from ptr; the first hit wins.
    always_comb begin
        win     = '0;
        win_idx = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s   = {1'b0, ptr} + (PW+1)'(k);
            cand_s  = (sum_s >= (PW+1)'(NREQ)) ? PW'(sum_s - (PW+1)'(NREQ)) : PW'(sum_s);
            hit_s   = !found_s && req[cand_s];
            win[cand_s] = win[cand_s] | hit_s;
            win_idx = hit_s ? cand_s : win_idx;
            found_s = found_s | hit_s;
        end
    end

endmodule

// File: rtl/decade_load_arbiter.sv
// Round-robin owner of the decade counter load port: GRANT/CHECK load transaction, count gating.
// Define DLA_LOAD_CHECK_EN to compile in the post-load compare, sticky load_err and its assertion.
module decade_load_arbiter
    import dla_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NREQ-1:0]                  req,
    input  logic [NREQ-1:0][DIGIT_W-1:0]     req_p,
    input  logic                             run,
    input  logic [DIGIT_W-1:0]               cnt_q,
    output logic [NREQ-1:0]                  gnt,
    output logic                             load,
    output logic [DIGIT_W-1:0]               p,
    output logic                             enable,
    output logic                             done,
    output logic                             load_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    dla_state_e         state_r, state_nxt_s;
    logic [PW-1:0]      ptr_r;
    logic [NREQ-1:0]    win_s;
    logic [PW-1:0]      win_idx_s;
    logic               cap_s;
    logic [NREQ-1:0]    gnt_r, gnt_nxt_s;
    logic               load_r, load_nxt_s;
    logic               done_r, done_nxt_s;
    logic [DIGIT_W-1:0] p_r;

    dla_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req     (req),
        .ptr     (ptr_r),
        .win     (win_s),
        .win_idx (win_idx_s)
    );

    // Next state plus next values of the registered strobes.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = '0;
        load_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        cap_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_nxt_s = GRANT;
                    gnt_nxt_s   = win_s;
                    load_nxt_s  = 1'b1;
                    cap_s       = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                state_nxt_s = CHECK;
                done_nxt_s  = 1'b1;
            end
            CHECK:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, strobes, priority pointer and captured load value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            load_r  <= 1'b0;
            done_r  <= 1'b0;
            ptr_r   <= '0;
            p_r     <= '0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            load_r  <= load_nxt_s;
            done_r  <= done_nxt_s;
            if (cap_s) begin
                ptr_r <= (win_idx_s == PW'(NREQ-1)) ? '0 : win_idx_s + PW'(1);
                p_r   <= clamp_digit(req_p[win_idx_s]);
            end
        end
    end

    assign gnt    = gnt_r;
    assign load   = load_r;
    assign done   = done_r;
    assign p      = p_r;
    // rst_n term keeps enable at its reset value while reset is asserted.
    assign enable = run & rst_n & (state_r == IDLE);

`ifdef DLA_LOAD_CHECK_EN
    logic load_err_r;

    // The counter registered p on the edge that ended GRANT, so it must match in CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_err_r <= 1'b0;
        end else if ((state_r == CHECK) && (cnt_q != p_r)) begin
            load_err_r <= 1'b1;
        end else begin
            load_err_r <= load_err_r;
        end
    end

    assign load_err = load_err_r;

    a_load_lands: assert property (@(posedge clk) disable iff (!rst_n) load |=> cnt_q == p);
`else
    logic unused_cnt_s;
    assign unused_cnt_s = ^cnt_q;
    assign load_err     = 1'b0;
`endif

endmodule

// File: tb/tb_decade_load_arbiter.sv
// Randomized and directed bench for decade_load_arbiter against a transaction-level reference model.
// A behavioural decade counter closes the loop on load/p/enable; define DLA_LOAD_CHECK_EN for the faulty-counter case.
module tb_decade_load_arbiter;

    localparam int NREQ = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NREQ-1:0]          req;
    logic [NREQ-1:0][3:0]     req_p;
    logic                     run;
    logic [3:0]               cnt_q;
    logic [NREQ-1:0]          gnt;
    logic                     load;
    logic [3:0]               p;
    logic                     enable;
    logic                     done;
    logic                     load_err;

    bit bad_cnt = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 granting, 2 checking.
    int              m_ph  = 0;
    int              m_ptr = 0;
    logic [NREQ-1:0] e_gnt = '0;
    logic            e_load = 1'b0;
    logic            e_done = 1'b0;
    logic [3:0]      e_p = 4'd0;
    logic            e_err = 1'b0;

    decade_load_arbiter #(.NREQ(NREQ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_p    (req_p),
        .run      (run),
        .cnt_q    (cnt_q),
        .gnt      (gnt),
        .load     (load),
        .p        (p),
        .enable   (enable),
        .done     (done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    // Behavioural decade counter, optionally loading the wrong value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt_q <= 4'd0;
        else if (load)   cnt_q <= bad_cnt ? p + 4'd1 : p;
        else if (enable) cnt_q <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_ptr = 0;
        e_gnt = '0; e_load = 1'b0; e_done = 1'b0; e_p = 4'd0; e_err = 1'b0;
    endtask

    task automatic model_edge();
        int w;
        int v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_gnt = '0; e_load = 1'b0; e_done = 1'b0;
        if (m_ph == 0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            if (w >= 0) begin
                e_gnt[w] = 1'b1;
                e_load   = 1'b1;
                v        = int'(req_p[w]);
                e_p      = 4'((v > 9) ? 9 : v);
                m_ptr    = (w + 1) % NREQ;
                m_ph     = 1;
            end
        end else if (m_ph == 1) begin
            e_done = 1'b1;
            m_ph   = 2;
        end else begin
            if (bad_cnt) e_err = 1'b1;
            m_ph = 0;
        end
    endtask

    task automatic check_outputs();
        chk("gnt",      32'(gnt),      32'(e_gnt));
        chk("load",     32'(load),     32'(e_load));
        chk("p",        32'(p),        32'(e_p));
        chk("done",     32'(done),     32'(e_done));
        chk("enable",   32'(enable),   32'(run && rst_n && m_ph == 0));
        chk("load_err", 32'(load_err), 32'(e_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        int rr_idx;
        int rr_last;
        int exp_order [5] = '{0, 1, 2, 3, 0};

        rst_n = 1'b0; req = '0; req_p = '0; run = 1'b1;
        model_reset();
        step(); step();
        rst_n = 1'b1;

        // Round-robin with every requester active from a fresh pointer.
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) req_p[i] = 4'($urandom_range(0, 15));
        rr_idx = 0; rr_last = -1;
        for (int c = 0; c < 13; c++) begin
            step();
            if (gnt != '0) begin
                if (rr_idx < 5) chk("rr_order", 32'(gnt), 32'(1 << exp_order[rr_idx]));
                if (rr_last >= 0) chk("rr_gap", 32'(c - rr_last), 32'd3);
                rr_last = c;
                rr_idx++;
            end
        end
        chk("rr_count", 32'(rr_idx), 32'd5);
        req = '0;
        repeat (3) step();

        // Single request.
        req = 4'b0001; req_p[0] = 4'd5; run = 1'b1;
        step();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_p", 32'(p), 32'd5);
        chk("single_en_g", 32'(enable), 32'd0);
        req = '0;
        step();
        chk("single_done", 32'(done), 32'd1);
        chk("single_en_c", 32'(enable), 32'd0);
        step();
        chk("single_en_i", 32'(enable), 32'd1);

        // Clamp of a non-BCD load value.
        req = 4'b0100; req_p[2] = 4'd12;
        step();
        chk("clamp_p", 32'(p), 32'd9);
        req = '0;
        repeat (2) step();

        // Request arriving during CHECK waits for the next IDLE sample.
        req = 4'b0001; req_p[0] = 4'd3;
        step();
        req = '0;
        step();
        req = 4'b1000; req_p[3] = 4'd7; run = 1'b0;
        step();
        chk("late_idle_gnt", 32'(gnt), 32'h0);
        run = 1'b1;
        step();
        chk("late_gnt", 32'(gnt), 32'h8);
        req = '0;
        repeat (2) step();

        // Reset during GRANT; pointer must restart at 0.
        req = 4'b0010; req_p[1] = 4'd4;
        step();
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        step(); step();
        rst_n = 1'b1;
        req = 4'b0110; req_p[1] = 4'd2; req_p[2] = 4'd8;
        step();
        chk("rst_gnt", 32'(gnt), 32'h2);
        req = '0;
        repeat (2) step();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            req = 4'($urandom) & 4'($urandom);
            for (int i = 0; i < NREQ; i++) req_p[i] = 4'($urandom_range(0, 15));
            run = 1'($urandom);
            step();
        end
        req = '0;
        repeat (3) step();

`ifdef DLA_LOAD_CHECK_EN
        // Counter that loads P+1 must raise the sticky error.
        bad_cnt = 1'b1;
        req = 4'b0001; req_p[0] = 4'd5;
        step();
        req = '0;
        step(); step();
        chk("err_set", 32'(load_err), 32'd1);
        bad_cnt = 1'b0;
        repeat (4) step();
        chk("err_sticky", 32'(load_err), 32'd1);
`else
        chk("err_tied", 32'(load_err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
